// File: rtl/xge_rx_pkg.sv
`default_nettype none
//============================================================================
// Package     : xge_rx_pkg
// Description : Shared types and helpers for the xge_mac receive-side reader.
// Revision    : 1.0 - initial release
//============================================================================
package xge_rx_pkg;

    typedef struct packed {
        logic        err;
        logic [2:0]  mod;
        logic        eop;
        logic        sop;
        logic [63:0] data;
    } rx_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // The MAC encodes a full 8-byte eop word as mod == 0.
    function automatic logic [3:0] mod2bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xge_rx_sync_fifo.sv
`default_nettype none
//============================================================================
// Module      : xge_rx_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with free count.
// Revision    : 1.0 - initial release
//============================================================================
module xge_rx_sync_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = 1;
    localparam logic [c_aw:0]   c_cnt_one = 1;
    localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_depth);
    assign o_free_cnt = c_depth - r_count;
    assign o_rd_data  = r_mem[r_rd_ptr];

    // A read frees the slot in the same cycle, so a full FIFO may accept a write alongside it.
    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/xge_rx_pkt_reader.sv
`default_nettype none
//============================================================================
// Module      : xge_rx_pkt_reader
// Description : Reads frames from xge_mac into a FIFO, streams them out and
//               keeps saturating per-frame statistics.
// Revision    : 1.0 - initial release
//============================================================================
module xge_rx_pkt_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BYTES  = 1518
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        enable,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_mod,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        stat_clr,
    output logic [31:0] stat_pkt_cnt,
    output logic [31:0] stat_err_cnt,
    output logic [15:0] stat_frm_err,
    output logic [15:0] stat_last_len
);

    import xge_rx_pkg::*;

    localparam int c_fc_w = $clog2(FIFO_DEPTH) + 1;

    rd_state_t   r_state;
    logic        r_in_pkt;
    logic [15:0] r_len;
    logic [31:0] r_stat_pkt_cnt;
    logic [31:0] r_stat_err_cnt;
    logic [15:0] r_stat_frm_err;
    logic [15:0] r_stat_last_len;

    logic [c_fc_w-1:0] w_free;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_wr;
    logic        w_fifo_rd;
    rx_word_t    w_wr_word;
    rx_word_t    w_rd_word;
    logic [3:0]  w_bytes;
    logic [16:0] w_sum;
    logic [15:0] w_len_next;
    logic        w_accept;
    logic        w_frm_viol;
    logic        w_eop_done;
    logic        w_frame_err;

    always_comb begin
        w_bytes     = pkt_rx_eop ? mod2bytes(pkt_rx_mod) : 4'd8;
        w_accept    = pkt_rx_val && (pkt_rx_sop || r_in_pkt);
        // Stray continuation word or a restart while a frame is still open.
        w_frm_viol  = pkt_rx_val && (pkt_rx_sop ? r_in_pkt : !r_in_pkt);
        w_sum       = (pkt_rx_sop ? 17'd0 : {1'b0, r_len}) + {13'd0, w_bytes};
        w_len_next  = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        w_eop_done  = w_accept && pkt_rx_eop;
        w_frame_err = pkt_rx_err || (int'(w_len_next) > MAX_BYTES);

        w_wr_word      = '0;
        w_wr_word.data = pkt_rx_data;
        w_wr_word.sop  = pkt_rx_sop;
        w_wr_word.eop  = pkt_rx_eop;
        w_wr_word.mod  = pkt_rx_eop ? pkt_rx_mod : 3'd0;
        w_wr_word.err  = w_eop_done && w_frame_err;
    end

    assign w_fifo_wr = w_accept;
    assign w_fifo_rd = out_ready && !w_fifo_empty;

    xge_rx_sync_fifo #(
        .WIDTH ($bits(rx_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_156m25),
        .rst_n      (reset_156m25_n),
        .i_wr_en    (w_fifo_wr),
        .i_wr_data  (w_wr_word),
        .i_rd_en    (w_fifo_rd),
        .o_rd_data  (w_rd_word),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_free_cnt (w_free)
    );

    // Two free slots: one for the word already in flight from the MAC, one for this request.
    assign pkt_rx_ren = (r_state == READ) && (w_free >= c_fc_w'(2));

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (enable && pkt_rx_avail) r_state <= READ;
                READ:    if (w_eop_done)             r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_in_pkt <= 1'b0;
            r_len    <= '0;
        end else if (w_accept) begin
            r_in_pkt <= !pkt_rx_eop;
            r_len    <= w_len_next;
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_stat_pkt_cnt  <= '0;
            r_stat_err_cnt  <= '0;
            r_stat_frm_err  <= '0;
            r_stat_last_len <= '0;
        end else if (stat_clr) begin
            r_stat_pkt_cnt  <= '0;
            r_stat_err_cnt  <= '0;
            r_stat_frm_err  <= '0;
            r_stat_last_len <= '0;
        end else begin
            if (w_eop_done) begin
                r_stat_last_len <= w_len_next;
                if (~&r_stat_pkt_cnt) begin
                    r_stat_pkt_cnt <= r_stat_pkt_cnt + 32'd1;
                end
                if (w_frame_err && ~&r_stat_err_cnt) begin
                    r_stat_err_cnt <= r_stat_err_cnt + 32'd1;
                end
            end
            if (w_frm_viol && ~&r_stat_frm_err) begin
                r_stat_frm_err <= r_stat_frm_err + 16'd1;
            end
        end
    end

    assign stat_pkt_cnt  = r_stat_pkt_cnt;
    assign stat_err_cnt  = r_stat_err_cnt;
    assign stat_frm_err  = r_stat_frm_err;
    assign stat_last_len = r_stat_last_len;

    // Gate by valid so stale FIFO storage never shows on the outputs.
    assign out_valid = !w_fifo_empty;
    assign out_data  = out_valid ? w_rd_word.data : 64'd0;
    assign out_sop   = out_valid && w_rd_word.sop;
    assign out_eop   = out_valid && w_rd_word.eop;
    assign out_mod   = out_valid ? w_rd_word.mod : 3'd0;
    assign out_err   = out_valid && w_rd_word.eop && w_rd_word.err;

endmodule
`default_nettype wire

// File: tb/tb_xge_rx_pkt_reader.sv
`default_nettype none
//============================================================================
// Module      : tb_xge_rx_pkt_reader
// Description : Scoreboard bench for xge_rx_pkt_reader with a simple MAC model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_xge_rx_pkt_reader;
    import xge_rx_pkg::*;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25_n;
    logic        enable;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_mod;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        stat_clr;
    logic [31:0] stat_pkt_cnt;
    logic [31:0] stat_err_cnt;
    logic [15:0] stat_frm_err;
    logic [15:0] stat_last_len;

    rx_word_t mac_q[$];
    rx_word_t raw_q[$];
    rx_word_t exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_156m25 = ~clk_156m25;

    xge_rx_pkt_reader #(.FIFO_DEPTH(16), .MAX_BYTES(1518)) dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .enable         (enable),
        .pkt_rx_avail   (pkt_rx_avail),
        .pkt_rx_ren     (pkt_rx_ren),
        .pkt_rx_data    (pkt_rx_data),
        .pkt_rx_val     (pkt_rx_val),
        .pkt_rx_sop     (pkt_rx_sop),
        .pkt_rx_eop     (pkt_rx_eop),
        .pkt_rx_mod     (pkt_rx_mod),
        .pkt_rx_err     (pkt_rx_err),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_mod        (out_mod),
        .out_err        (out_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .stat_clr       (stat_clr),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_err_cnt   (stat_err_cnt),
        .stat_frm_err   (stat_frm_err),
        .stat_last_len  (stat_last_len)
    );

    // MAC model: a word requested in one cycle is presented in the next.
    initial begin
        logic    r_ren;
        rx_word_t w;
        pkt_rx_avail = 1'b0;
        pkt_rx_val   = 1'b0;
        pkt_rx_data  = '0;
        pkt_rx_sop   = 1'b0;
        pkt_rx_eop   = 1'b0;
        pkt_rx_mod   = '0;
        pkt_rx_err   = 1'b0;
        forever begin
            @(negedge clk_156m25);
            r_ren = pkt_rx_ren;
            @(posedge clk_156m25);
            #1;
            w = '0;
            pkt_rx_val = 1'b0;
            if (reset_156m25_n) begin
                if (raw_q.size() != 0) begin
                    w = raw_q.pop_front();
                    pkt_rx_val = 1'b1;
                end else if (r_ren && mac_q.size() != 0) begin
                    w = mac_q.pop_front();
                    pkt_rx_val = 1'b1;
                end
            end
            pkt_rx_data  = w.data;
            pkt_rx_sop   = w.sop;
            pkt_rx_eop   = w.eop;
            pkt_rx_mod   = w.mod;
            pkt_rx_err   = w.err;
            pkt_rx_avail = (mac_q.size() != 0);
        end
    end

    // Monitor: compares every accepted output word against the scoreboard.
    initial begin
        rx_word_t e;
        bit ok;
        forever begin
            @(negedge clk_156m25);
            if (reset_156m25_n) begin
                if (dut.w_fifo_wr && dut.w_fifo_full && !dut.w_fifo_rd) begin
                    n_total++;
                    $display("FAIL fifo_overflow: write while full (wr=1 full=1 rd=0), required no write");
                end
                if (out_valid && out_ready) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_word: got data=%h sop=%b eop=%b, required no word",
                                 out_data, out_sop, out_eop);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (out_data === e.data) && (out_sop === e.sop) && (out_eop === e.eop);
                        if (e.eop) ok = ok && (out_mod === e.mod) && (out_err === e.err);
                        if (ok) n_pass++;
                        else $display("FAIL out_word: got data=%h sop=%b eop=%b mod=%0d err=%b, required data=%h sop=%b eop=%b mod=%0d err=%b",
                                      out_data, out_sop, out_eop, out_mod, out_err,
                                      e.data, e.sop, e.eop, e.mod, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_156m25);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic push_word(input logic [63:0] d, input bit sop, input bit eop,
                             input logic [2:0] mod, input bit mac_err, input bit exp_err);
        rx_word_t w;
        w.data = d;
        w.sop  = sop;
        w.eop  = eop;
        w.mod  = eop ? mod : 3'd0;
        w.err  = mac_err;
        mac_q.push_back(w);
        w.err  = exp_err;
        exp_q.push_back(w);
    endtask

    task automatic send_frame(input int id, input int nwords, input logic [2:0] mod,
                              input bit mac_err, input bit exp_err);
        for (int i = 0; i < nwords; i++) begin
            push_word({8'(id), 24'h0, 32'(i)}, i == 0, i == nwords - 1, mod,
                      mac_err && (i == nwords - 1), exp_err && (i == nwords - 1));
        end
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        if (cyc >= 3000) begin
            n_total++;
            $display("FAIL %s_timeout: %0d words still pending, required 0", name, exp_q.size());
        end
        tick(3);
    endtask

    initial begin
        reset_156m25_n = 1'b0;
        enable         = 1'b0;
        out_ready      = 1'b0;
        stat_clr       = 1'b0;
        tick(3);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ren", 32'(pkt_rx_ren), 0);
        chk("rst_pkt_cnt", stat_pkt_cnt, 0);
        chk("rst_err_cnt", stat_err_cnt, 0);
        chk("rst_frm_err", 32'(stat_frm_err), 0);
        chk("rst_last_len", 32'(stat_last_len), 0);
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        tick(2);
        enable    = 1'b1;
        out_ready = 1'b1;

        // 64-byte frame
        send_frame(1, 8, 3'd0, 1'b0, 1'b0);
        drain("t1");
        chk("t1_pkt_cnt", stat_pkt_cnt, 1);
        chk("t1_err_cnt", stat_err_cnt, 0);
        chk("t1_last_len", 32'(stat_last_len), 64);

        // 61-byte frame with MAC error
        send_frame(2, 8, 3'd5, 1'b1, 1'b1);
        drain("t2");
        chk("t2_pkt_cnt", stat_pkt_cnt, 2);
        chk("t2_err_cnt", stat_err_cnt, 1);
        chk("t2_last_len", 32'(stat_last_len), 61);

        // enable low: frame waits in the MAC
        enable = 1'b0;
        send_frame(3, 8, 3'd0, 1'b0, 1'b0);
        tick(10);
        chk("en_off_ren", 32'(pkt_rx_ren), 0);
        chk("en_off_mac_left", 32'(mac_q.size()), 8);
        enable = 1'b1;
        drain("en");
        chk("en_pkt_cnt", stat_pkt_cnt, 3);

        // 1600-byte oversize frame, enable dropped mid-frame
        send_frame(4, 200, 3'd0, 1'b0, 1'b1);
        tick(30);
        enable = 1'b0;
        drain("t3");
        chk("t3_pkt_cnt", stat_pkt_cnt, 4);
        chk("t3_err_cnt", stat_err_cnt, 2);
        chk("t3_last_len", 32'(stat_last_len), 1600);
        chk("t3_ren_after", 32'(pkt_rx_ren), 0);
        enable = 1'b1;

        // backpressure: FIFO fills to 16 entries and reading stops
        out_ready = 1'b0;
        send_frame(5, 200, 3'd0, 1'b0, 1'b1);
        tick(60);
        chk("t4_ren_stalled", 32'(pkt_rx_ren), 0);
        chk("t4_mac_left", 32'(mac_q.size()), 184);
        chk("t4_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        drain("t4");
        chk("t4_pkt_cnt", stat_pkt_cnt, 5);
        chk("t4_err_cnt", stat_err_cnt, 3);
        chk("t4_last_len", 32'(stat_last_len), 1600);

        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        chk("clr_pkt_cnt", stat_pkt_cnt, 0);
        chk("clr_err_cnt", stat_err_cnt, 0);
        chk("clr_last_len", 32'(stat_last_len), 0);

        // stray word while idle, then a frame with a restart
        begin
            rx_word_t w;
            w = '0;
            w.data = 64'hDEAD_BEEF_0000_0001;
            raw_q.push_back(w);
        end
        tick(5);
        chk("t5_frm_err_drop", 32'(stat_frm_err), 1);
        chk("t5_drop_valid", 32'(out_valid), 0);
        chk("t5_drop_pkt", stat_pkt_cnt, 0);
        push_word(64'h0600_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        push_word(64'h0600_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        push_word(64'h0600_0000_0000_0002, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        push_word(64'h0600_0000_0000_0003, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        drain("t5");
        chk("t5_frm_err", 32'(stat_frm_err), 2);
        chk("t5_pkt_cnt", stat_pkt_cnt, 1);
        chk("t5_last_len", 32'(stat_last_len), 24);

        // reset in the middle of a frame
        out_ready = 1'b0;
        send_frame(7, 20, 3'd0, 1'b0, 1'b0);
        tick(10);
        @(negedge clk_156m25);
        reset_156m25_n = 1'b0;
        mac_q.delete();
        exp_q.delete();
        #1;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_data", out_data[31:0], 0);
        chk("t6_out_sop", 32'(out_sop), 0);
        chk("t6_ren", 32'(pkt_rx_ren), 0);
        chk("t6_pkt_cnt", stat_pkt_cnt, 0);
        chk("t6_frm_err", 32'(stat_frm_err), 0);
        tick(3);
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        out_ready = 1'b1;
        tick(2);
        send_frame(8, 8, 3'd0, 1'b0, 1'b0);
        drain("t6");
        chk("t6_post_pkt_cnt", stat_pkt_cnt, 1);
        chk("t6_post_last_len", 32'(stat_last_len), 64);
        chk("t6_post_frm_err", 32'(stat_frm_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
